winograd_in_tf: RTL

WINOGRAD_IN_TF -- requirements
Module: winograd_in_tf

---
 rtl/winograd_in_tf.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/winograd_in_tf.sv
// Winograd F(2,3) input transform U = B^T d B on 4x4 tiles, one column per beat in and out.
// Latency: the column stage runs on accept; a tile is drainable the cycle after its 4th column is accepted.
// Backpressure: two ping-pong V banks; in_ready drops only when both banks hold undrained tiles.
// Optional: define WINO_IN_SAT_EN to saturate outputs to 32-bit signed range instead of wrapping.
module winograd_in_tf (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_1,
  input  logic signed [31:0] in_2,
  input  logic signed [31:0] in_3,
  input  logic signed [31:0] in_4,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_1,
  output logic signed [31:0] out_2,
  output logic signed [31:0] out_3,
  output logic signed [31:0] out_4,
  output logic               out_last
);

  // Control state
  logic [1:0] full_q, full_d;
  logic       wptr_q, wptr_d;
  logic       rptr_q, rptr_d;
  logic [1:0] wcol_q, wcol_d;
  logic [1:0] rcol_q, rcol_d;

  // V storage, indexed [bank][column][row]; contents need no reset
  logic signed [32:0] bank_q [2][4][4];
  logic signed [32:0] bank_d [2][4][4];

  logic signed [32:0] d_ext [4];
  logic signed [32:0] v_col [4];
  logic signed [33:0] vx    [4][4];   // read bank widened, [column][row]
  logic signed [33:0] u_col [4];      // row-stage result for column rcol, [row]

  logic in_acc;
  logic out_acc;

  assign in_ready  = ~full_q[wptr_q];
  assign out_valid = full_q[rptr_q];
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;
  assign out_last  = out_valid & (rcol_q == 2'd3);

  // Reduce a 34-bit row-stage result to the 32-bit output format
  function automatic logic [31:0] fit32(input logic signed [33:0] x);
`ifdef WINO_IN_SAT_EN
    if (x[33:31] == 3'b000 || x[33:31] == 3'b111) begin
      fit32 = x[31:0];
    end else if (x[33]) begin
      fit32 = 32'h8000_0000;
    end else begin
      fit32 = 32'h7FFF_FFFF;
    end
`else
    fit32 = 32'(x);
`endif
  endfunction

  // Column stage: V[:,k] = B^T d[:,k], computed on the incoming beat
  always_comb begin
    d_ext[0] = {in_1[31], in_1};
    d_ext[1] = {in_2[31], in_2};
    d_ext[2] = {in_3[31], in_3};
    d_ext[3] = {in_4[31], in_4};
    v_col[0] = d_ext[0] - d_ext[2];
    v_col[1] = d_ext[1] + d_ext[2];
    v_col[2] = d_ext[2] - d_ext[1];
    v_col[3] = d_ext[1] - d_ext[3];
  end

  // Bank write: store the transformed column into the write bank at wcol
  always_comb begin
    bank_d = bank_q;
    if (in_acc) begin
      for (int r = 0; r < 4; r++) begin
        bank_d[wptr_q][wcol_q][r] = v_col[r];
      end
    end
  end

  // Sign-extend the read bank to the row-stage width
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        vx[c][r] = {bank_q[rptr_q][c][r][32], bank_q[rptr_q][c][r]};
      end
    end
  end

  // Row stage: output column rcol combines two stored V columns per row
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      case (rcol_q)
        2'd0:    u_col[r] = vx[0][r] - vx[2][r];
        2'd1:    u_col[r] = vx[1][r] + vx[2][r];
        2'd2:    u_col[r] = vx[2][r] - vx[1][r];
        default: u_col[r] = vx[1][r] - vx[3][r];
      endcase
    end
  end

  // Output data, held at zero whenever no beat is presented
  always_comb begin
    out_1 = '0;
    out_2 = '0;
    out_3 = '0;
    out_4 = '0;
    if (out_valid) begin
      out_1 = fit32(u_col[0]);
      out_2 = fit32(u_col[1]);
      out_3 = fit32(u_col[2]);
      out_4 = fit32(u_col[3]);
    end
  end

  // Next-state for pointers, column counters and full flags; fill and drain
  // always target different banks, so both updates can land in one cycle
  always_comb begin
    full_d = full_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    wcol_d = wcol_q;
    rcol_d = rcol_q;
    if (in_acc) begin
      wcol_d = wcol_q + 2'd1;
      if (wcol_q == 2'd3) begin
        full_d[wptr_q] = 1'b1;
        wptr_d         = ~wptr_q;
      end
    end
    if (out_acc) begin
      rcol_d = rcol_q + 2'd1;
      if (rcol_q == 2'd3) begin
        full_d[rptr_q] = 1'b0;
        rptr_d         = ~rptr_q;
      end
    end
  end

  // Control registers; reset discards any partial or stored tile
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 2'b00;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      wcol_q <= 2'd0;
      rcol_q <= 2'd0;
    end else begin
      full_q <= full_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      wcol_q <= wcol_d;
      rcol_q <= rcol_d;
    end
  end

  // Bank storage registers
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule
